// File: rtl/ser16_pkg.sv
// Shared types and constants for the 16-bit parallel-to-serial transmitter.
package ser16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_counter.sv
// Modulo-WIDTH bit index with synchronous clear/increment and a terminal-count flag.
module bit_counter #(
    parameter int WIDTH = 16,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(WIDTH - 1));

    // Clear wins over increment so a back-to-back reload restarts at index 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/ser16_tx.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word and emits it one bit per clock with framing.
module ser16_tx
    import ser16_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sframe,
    output logic             slast
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             tc;
    logic [CW-1:0]    index;
    logic [CW-1:0]    bit_sel;
    logic [WIDTH-1:0] shreg;

    assign accept  = in_valid && in_ready;
    assign bit_sel = MSB_FIRST ? (CW'(WIDTH - 1) - index) : index;

    bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .inc   (state == SHIFT),
        .count (index),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  state_next = accept ? SHIFT : IDLE;
            SHIFT: if (tc) state_next = accept ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The word is held still and the index selects the outgoing bit, so a
    // reload at the terminal count simply overwrites it with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= in;
        end
    end

    // in_ready drops while reset is asserted so nothing is taken at a reset edge.
    always_comb begin
        in_ready = 1'b0;
        sframe   = 1'b0;
        slast    = 1'b0;
        sout     = 1'b0;
        if (rst_n) begin
            in_ready = (state == IDLE) || tc;
        end
        if (state == SHIFT) begin
            sframe = 1'b1;
            slast  = tc;
            sout   = shreg[bit_sel];
        end
    end

endmodule

// File: tb/tb_ser16_tx.sv
// Self-checking bench for ser16_tx: LSB-first and MSB-first instances against a bit-stream model.
module tb_ser16_tx;

    typedef struct packed {
        logic lsb_bit;
        logic msb_bit;
        logic last;
    } exp_bit_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_word = 16'h0000;
    logic        in_valid = 1'b0;

    logic ready_l, sout_l, sframe_l, slast_l;
    logic ready_m, sout_m, sframe_m, slast_m;

    exp_bit_t exp_q[$];
    exp_bit_t cur;
    logic     cur_valid = 1'b0;
    logic     cap_l[$];
    logic     cap_m[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ser16_tx #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_word),
        .in_valid (in_valid),
        .in_ready (ready_l),
        .sout     (sout_l),
        .sframe   (sframe_l),
        .slast    (slast_l)
    );

    ser16_tx #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_word),
        .in_valid (in_valid),
        .in_ready (ready_m),
        .sout     (sout_m),
        .sframe   (sframe_m),
        .slast    (slast_m)
    );

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    // The model is a queue of bits still to be shown; the current bit is what the outputs carry now.
    task automatic checkOutput();
        logic exp_ready;
        exp_ready = rst_n && (!cur_valid || cur.last);
        checkBit("in_ready_lsb", ready_l, exp_ready);
        checkBit("in_ready_msb", ready_m, exp_ready);
        checkBit("sframe_lsb", sframe_l, cur_valid);
        checkBit("sframe_msb", sframe_m, cur_valid);
        checkBit("slast_lsb", slast_l, cur_valid && cur.last);
        checkBit("slast_msb", slast_m, cur_valid && cur.last);
        checkBit("sout_lsb", sout_l, cur_valid ? cur.lsb_bit : 1'b0);
        checkBit("sout_msb", sout_m, cur_valid ? cur.msb_bit : 1'b0);
        if (sframe_l === 1'b1) cap_l.push_back(sout_l);
        if (sframe_m === 1'b1) cap_m.push_back(sout_m);
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [15:0] w);
        logic acc;
        exp_bit_t e;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        in_word  = w;
        #1;
        checkOutput();
        acc = r && v && (!cur_valid || cur.last);
        @(posedge clk);
        if (!r) begin
            exp_q.delete();
            cur_valid = 1'b0;
        end else begin
            if (acc) begin
                for (int i = 0; i < 16; i++) begin
                    e.lsb_bit = w[i];
                    e.msb_bit = w[15 - i];
                    e.last    = (i == 15);
                    exp_q.push_back(e);
                end
            end
            if (exp_q.size() > 0) begin
                cur       = exp_q.pop_front();
                cur_valid = 1'b1;
            end else begin
                cur_valid = 1'b0;
            end
        end
    endtask

    // Rebuilds a word from captured serial bits, in the bit order the instance should use.
    task automatic checkCapture(input string tag, input bit use_msb, input int base, input logic [15:0] expected);
        logic [15:0] word;
        int n;
        word = 16'h0000;
        n = use_msb ? cap_m.size() : cap_l.size();
        checks++;
        assert (n >= base + 16)
        else begin
            errors++;
            $error("[TB] FAIL %s_count observed=%0d expected>=%0d", tag, n, base + 16);
        end
        if (n >= base + 16) begin
            for (int i = 0; i < 16; i++) begin
                if (use_msb) word[15 - i] = cap_m[base + i];
                else         word[i]      = cap_l[base + i];
            end
            checks++;
            assert (word === expected)
            else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, word, expected);
            end
        end
    endtask

    initial begin
        logic [15:0] w;
        repeat (2) @(posedge clk);

        $display("[TB] reset and idle");
        applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'hBEEF);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 16'($urandom()));

        $display("[TB] 0xA5C3 with 0x1234 offered from index 5");
        cap_l.delete(); cap_m.delete();
        applyStimulus(1'b1, 1'b1, 16'hA5C3);
        for (int k = 0; k < 16; k++) begin
            if (k >= 5) applyStimulus(1'b1, 1'b1, 16'h1234);
            else        applyStimulus(1'b1, 1'b0, 16'($urandom()));
        end
        for (int k = 0; k < 17; k++) applyStimulus(1'b1, 1'b0, 16'($urandom()));
        checkCapture("a5c3_lsb", 1'b0, 0, 16'hA5C3);
        checkCapture("a5c3_msb", 1'b1, 0, 16'hA5C3);
        checkCapture("after_1234_lsb", 1'b0, 16, 16'h1234);

        $display("[TB] 0xFFFF then 0x0000 back to back");
        cap_l.delete(); cap_m.delete();
        applyStimulus(1'b1, 1'b1, 16'hFFFF);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) applyStimulus(1'b1, 1'b1, 16'h0000);
            else         applyStimulus(1'b1, 1'b0, 16'($urandom()));
        end
        for (int k = 0; k < 17; k++) applyStimulus(1'b1, 1'b0, 16'($urandom()));
        checkCapture("ffff_lsb", 1'b0, 0, 16'hFFFF);
        checkCapture("zero_lsb", 1'b0, 16, 16'h0000);

        $display("[TB] MSB-first 0x8001");
        cap_l.delete(); cap_m.delete();
        applyStimulus(1'b1, 1'b1, 16'h8001);
        for (int k = 0; k < 17; k++) applyStimulus(1'b1, 1'b0, 16'h0000);
        checkCapture("8001_msb", 1'b1, 0, 16'h8001);
        checkCapture("8001_lsb", 1'b0, 0, 16'h8001);

        $display("[TB] reset at index 7");
        applyStimulus(1'b1, 1'b1, 16'($urandom()));
        for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b0, 16'($urandom()));
        applyStimulus(1'b0, 1'b1, 16'($urandom()));
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, 16'($urandom()));

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            w = 16'($urandom());
            applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0), w);
        end
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser16_tx.md
SER16_TX -- requirements
Module: ser16_tx

Interface
REQ-001 Parameter WIDTH, default 16, sets the word width in bits; only 16 is required to be supported.
REQ-002 Parameter MSB_FIRST, default 0: 0 sends LSB first, 1 sends MSB first.
REQ-003 Port clk  input  1  single rising-edge clock for all state.
REQ-004 Port rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 Port in  input  WIDTH  parallel word to transmit.
REQ-006 Port in_valid  input  1  in holds a word offered for transmission.
REQ-007 Port in_ready  output  1  block can accept a word this cycle.
REQ-008 Port sout  output  1  serial data bit.
REQ-009 Port sframe  output  1  high in every cycle where sout carries a valid bit.
REQ-010 Port slast  output  1  high with the final bit of each word.

Function
REQ-011 States SHALL be IDLE and SHIFT.
REQ-012 Accept SHALL occur on a rising edge where in_valid and in_ready are both 1; in is captured into the shift register at that edge.
REQ-013 in_ready SHALL be 1 in IDLE, and in SHIFT only when the bit index equals WIDTH-1; otherwise 0.
REQ-014 Accept from IDLE SHALL move to SHIFT with bit index 0; the first bit SHALL appear on sout in the cycle after the accept edge (latency 1).
REQ-015 In SHIFT, sframe SHALL be 1, and sout SHALL carry bit[index] (MSB_FIRST=0) or bit[WIDTH-1-index] (MSB_FIRST=1).
REQ-016 The bit index SHALL increment by 1 each cycle in SHIFT, for exactly WIDTH cycles per word.
REQ-017 slast SHALL be 1 only when sframe is 1 and the index equals WIDTH-1.
REQ-018 At index WIDTH-1 with an accept, the block SHALL reload, set index 0 and stay in SHIFT, giving gapless back-to-back words.
REQ-019 At index WIDTH-1 without an accept, the block SHALL return to IDLE.
REQ-020 Changes on in or in_valid while in_ready=0 SHALL NOT affect the word being sent.
REQ-021 In IDLE, sout, sframe and slast SHALL be 0.
REQ-022 All outputs SHALL be registered or decoded only from state and index, with no combinational path from in or in_valid to any output.

Reset
REQ-023 While rst_n=0 at a clock edge: state=IDLE, index=0, shift register=0, sout=0, sframe=0, slast=0.
REQ-024 in_ready SHALL be 0 in any cycle where rst_n is sampled 0, and 1 in the first cycle after rst_n returns to 1.
REQ-025 Reset during SHIFT SHALL abort the word: no further bits and no slast for the partial word.

Structure
REQ-026 Package ser16_pkg SHALL hold the state enum (IDLE, SHIFT) and the default WIDTH constant 16.
REQ-027 Sub-module bit_counter SHALL provide a clear/increment mod-WIDTH index with a terminal-count flag (index == WIDTH-1).
REQ-028 Total RTL SHALL be 120-400 lines.

Verification
REQ-029 Word 0xA5C3, MSB_FIRST=0 -> sout over 16 cycles is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, with slast on the 16th bit only.
REQ-030 Word 0xFFFF accepted, then 0x0000 offered at index 15 -> 32 consecutive sframe=1 cycles: 16 ones then 16 zeros, slast high at cycles 16 and 32.
REQ-031 in changed to 0x1234 with in_valid=1 at index 5 of 0xA5C3 -> 0xA5C3 sent unchanged, and 0x1234 accepted only at index 15.
REQ-032 rst_n=0 for 1 cycle at index 7 -> next cycle sframe=0, slast never asserts, in_ready=1 the cycle after rst_n rises.
REQ-033 MSB_FIRST=1, word 0x8001 -> sout is 1, then 14 zeros, then 1.
REQ-034 Idle with in_valid=0 for 20 cycles -> sframe=0, sout=0, in_ready=1 throughout.
